// File: rtl/alu_port_arbiter.sv
// Four-port round-robin command scheduler in front of the ALU input stage.
// Each port holds one command until granted, then waits for its tagged response.
module alu_port_arbiter #(
    parameter int DW = 32
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic [3:0]    req1_cmd_in,
    input  logic [DW-1:0] req1_data1_in,
    input  logic [DW-1:0] req1_data2_in,
    input  logic [3:0]    req2_cmd_in,
    input  logic [DW-1:0] req2_data1_in,
    input  logic [DW-1:0] req2_data2_in,
    input  logic [3:0]    req3_cmd_in,
    input  logic [DW-1:0] req3_data1_in,
    input  logic [DW-1:0] req3_data2_in,
    input  logic [3:0]    req4_cmd_in,
    input  logic [DW-1:0] req4_data1_in,
    input  logic [DW-1:0] req4_data2_in,
    input  logic          alu_ready,
    input  logic [1:0]    alu_resp_in,
    input  logic [1:0]    alu_resp_port,
    input  logic [DW-1:0] alu_out_in,
    output logic [3:0]    prio_cmd,
    output logic [DW-1:0] prio_data1,
    output logic [DW-1:0] prio_data2,
    output logic [1:0]    prio_port,
    output logic [1:0]    out1_resp,
    output logic [DW-1:0] out1_data,
    output logic [1:0]    out2_resp,
    output logic [DW-1:0] out2_data,
    output logic [1:0]    out3_resp,
    output logic [DW-1:0] out3_data,
    output logic [1:0]    out4_resp,
    output logic [DW-1:0] out4_data
);
    localparam int NP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2
    } port_state_t;

    logic [3:0]    req_cmd   [NP];
    logic [DW-1:0] req_data1 [NP];
    logic [DW-1:0] req_data2 [NP];
    logic [3:0]    hold_cmd  [NP];
    logic [DW-1:0] hold_data1[NP];
    logic [DW-1:0] hold_data2[NP];
    logic [1:0]    resp_vec  [NP];
    logic [DW-1:0] data_vec  [NP];
    logic [NP-1:0] pend;
    logic [NP-1:0] waiting;

    logic          grant_valid;
    logic [1:0]    grant_port;
    logic [1:0]    last_reg;
    logic          resp_hit;

    assign req_cmd[0] = req1_cmd_in;
    assign req_cmd[1] = req2_cmd_in;
    assign req_cmd[2] = req3_cmd_in;
    assign req_cmd[3] = req4_cmd_in;
    assign req_data1[0] = req1_data1_in;
    assign req_data1[1] = req2_data1_in;
    assign req_data1[2] = req3_data1_in;
    assign req_data1[3] = req4_data1_in;
    assign req_data2[0] = req1_data2_in;
    assign req_data2[1] = req2_data2_in;
    assign req_data2[2] = req3_data2_in;
    assign req_data2[3] = req4_data2_in;

    // Responses for ports that are not waiting are dropped entirely.
    assign resp_hit = (alu_resp_in != 2'd0) && waiting[alu_resp_port];

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_port
            localparam logic [1:0] PID = 2'(gi);

            port_state_t   state_reg;
            port_state_t   state_next;
            logic          capture;
            logic [3:0]    cmd_reg;
            logic [DW-1:0] data1_reg;
            logic [DW-1:0] data2_reg;
            logic [1:0]    resp_reg;
            logic [DW-1:0] out_data_reg;

            always_ff @(posedge c_clk) begin
                if (!reset) begin
                    state_reg <= IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    IDLE: if (req_cmd[gi] != 4'd0) state_next = PEND;
                    PEND: if (grant_valid && grant_port == PID) state_next = WAIT;
                    WAIT: if (alu_resp_in != 2'd0 && alu_resp_port == PID) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end

            always_comb begin
                capture = (state_reg == IDLE) && (req_cmd[gi] != 4'd0);
                pend[gi] = (state_reg == PEND);
                waiting[gi] = (state_reg == WAIT);
            end

            always_ff @(posedge c_clk) begin
                if (!reset) begin
                    cmd_reg   <= '0;
                    data1_reg <= '0;
                    data2_reg <= '0;
                end else if (capture) begin
                    cmd_reg   <= req_cmd[gi];
                    data1_reg <= req_data1[gi];
                    data2_reg <= req_data2[gi];
                end
            end

            always_ff @(posedge c_clk) begin
                if (!reset) begin
                    resp_reg     <= '0;
                    out_data_reg <= '0;
                end else if (resp_hit && alu_resp_port == PID) begin
                    resp_reg     <= alu_resp_in;
                    out_data_reg <= alu_out_in;
                end else begin
                    resp_reg     <= '0;
                end
            end

            assign hold_cmd[gi]   = cmd_reg;
            assign hold_data1[gi] = data1_reg;
            assign hold_data2[gi] = data2_reg;
            assign resp_vec[gi]   = resp_reg;
            assign data_vec[gi]   = out_data_reg;
        end
    endgenerate

    // Search last+1 .. last+4 (wrapping), so the last winner has lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = last_reg;
        for (int k = 1; k <= NP; k++) begin
            if (!grant_valid && alu_ready && pend[last_reg + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_port  = last_reg + 2'(k);
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            last_reg   <= 2'd3;
            prio_cmd   <= '0;
            prio_data1 <= '0;
            prio_data2 <= '0;
            prio_port  <= '0;
        end else if (grant_valid) begin
            last_reg   <= grant_port;
            prio_cmd   <= hold_cmd[grant_port];
            prio_data1 <= hold_data1[grant_port];
            prio_data2 <= hold_data2[grant_port];
            prio_port  <= grant_port;
        end else begin
            prio_cmd   <= '0;
        end
    end

    assign out1_resp = resp_vec[0];
    assign out2_resp = resp_vec[1];
    assign out3_resp = resp_vec[2];
    assign out4_resp = resp_vec[3];
    assign out1_data = data_vec[0];
    assign out2_data = data_vec[1];
    assign out3_data = data_vec[2];
    assign out4_data = data_vec[3];

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Bench for alu_port_arbiter: directed scenarios with fixed expectations,
// then random traffic against a transaction-level reference model.
module tb_alu_port_arbiter;
    localparam int DW = 32;

    logic          c_clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cmd [4];
    logic [DW-1:0] d1  [4];
    logic [DW-1:0] d2  [4];
    logic          alu_ready;
    logic [1:0]    resp_in;
    logic [1:0]    resp_port;
    logic [DW-1:0] alu_out;
    logic [3:0]    prio_cmd;
    logic [DW-1:0] prio_data1;
    logic [DW-1:0] prio_data2;
    logic [1:0]    prio_port;
    logic [1:0]    o_resp [4];
    logic [DW-1:0] o_data [4];

    int checks = 0;
    int errors = 0;

    // Reference model: which ports own a command, which have been issued.
    bit            m_holding [4];
    bit            m_issued  [4];
    logic [3:0]    m_cmd [4];
    logic [DW-1:0] m_d1 [4];
    logic [DW-1:0] m_d2 [4];
    int            m_last;
    logic [3:0]    e_cmd;
    logic [DW-1:0] e_d1;
    logic [DW-1:0] e_d2;
    logic [1:0]    e_port;
    logic [1:0]    e_resp [4];
    logic [DW-1:0] e_data [4];

    always #5 c_clk = ~c_clk;

    alu_port_arbiter #(.DW(DW)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd[0]), .req1_data1_in(d1[0]), .req1_data2_in(d2[0]),
        .req2_cmd_in(cmd[1]), .req2_data1_in(d1[1]), .req2_data2_in(d2[1]),
        .req3_cmd_in(cmd[2]), .req3_data1_in(d1[2]), .req3_data2_in(d2[2]),
        .req4_cmd_in(cmd[3]), .req4_data1_in(d1[3]), .req4_data2_in(d2[3]),
        .alu_ready(alu_ready), .alu_resp_in(resp_in), .alu_resp_port(resp_port),
        .alu_out_in(alu_out),
        .prio_cmd(prio_cmd), .prio_data1(prio_data1), .prio_data2(prio_data2),
        .prio_port(prio_port),
        .out1_resp(o_resp[0]), .out1_data(o_data[0]),
        .out2_resp(o_resp[1]), .out2_data(o_data[1]),
        .out3_resp(o_resp[2]), .out3_data(o_data[2]),
        .out4_resp(o_resp[3]), .out4_data(o_data[3])
    );

    function automatic void model_edge();
        bit was_holding [4];
        bit was_issued  [4];
        int g = -1;
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                m_holding[p] = 0; m_issued[p] = 0;
                e_resp[p] = '0; e_data[p] = '0;
            end
            m_last = 3; e_cmd = '0; e_d1 = '0; e_d2 = '0; e_port = '0;
            return;
        end
        for (int p = 0; p < 4; p++) begin
            was_holding[p] = m_holding[p];
            was_issued[p]  = m_issued[p];
            e_resp[p]      = '0;
        end
        if (alu_ready) begin
            for (int k = 1; k <= 4; k++) begin
                int p = (m_last + k) % 4;
                if (g < 0 && was_holding[p] && !was_issued[p]) g = p;
            end
        end
        if (resp_in != 0 && was_issued[resp_port]) begin
            e_resp[resp_port] = resp_in;
            e_data[resp_port] = alu_out;
            m_holding[resp_port] = 0;
            m_issued[resp_port]  = 0;
        end
        for (int p = 0; p < 4; p++) begin
            if (!was_holding[p] && cmd[p] != 0) begin
                m_holding[p] = 1;
                m_cmd[p] = cmd[p]; m_d1[p] = d1[p]; m_d2[p] = d2[p];
            end
        end
        if (g >= 0) begin
            e_cmd = m_cmd[g]; e_d1 = m_d1[g]; e_d2 = m_d2[g];
            e_port = 2'(g); m_issued[g] = 1; m_last = g;
        end else begin
            e_cmd = '0;
        end
    endfunction

    task automatic tick();
        @(posedge c_clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = '0; d1[p] = '0; d2[p] = '0;
        end
        alu_ready = 1'b1; resp_in = '0; resp_port = '0; alu_out = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        cmd[0] = 4'd9; d1[0] = 32'hdead; resp_in = 2'd1; alu_out = 32'hbeef;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_inputs();
        checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL reset_prio_cmd got %0h want 0", prio_cmd); end
        checks++; if (prio_data1 !== '0 || prio_data2 !== '0) begin errors++; $display("FAIL reset_prio_data got %0h/%0h want 0/0", prio_data1, prio_data2); end
        checks++; if (prio_port !== 2'd0) begin errors++; $display("FAIL reset_prio_port got %0d want 0", prio_port); end
        for (int p = 0; p < 4; p++) begin
            checks++; if (o_resp[p] !== 2'd0 || o_data[p] !== '0) begin errors++; $display("FAIL reset_out%0d got %0d/%0h want 0/0", p + 1, o_resp[p], o_data[p]); end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        cmd[0] = 4'd1; d1[0] = 32'd5; d2[0] = 32'd7;
        tick();
        clear_inputs();
        checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL single_early got %0h want 0", prio_cmd); end
        tick();
        checks++; if (prio_cmd !== 4'd1 || prio_data1 !== 32'd5 || prio_data2 !== 32'd7 || prio_port !== 2'd0) begin
            errors++; $display("FAIL single_issue got %0h %0d %0d %0d want 1 5 7 0", prio_cmd, prio_data1, prio_data2, prio_port); end
        resp_in = 2'd1; resp_port = 2'd0; alu_out = 32'd12;
        tick();
        clear_inputs();
        checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL single_pulse got %0h want 0", prio_cmd); end
        checks++; if (o_resp[0] !== 2'd1 || o_data[0] !== 32'd12) begin errors++; $display("FAIL single_resp got %0d/%0d want 1/12", o_resp[0], o_data[0]); end
        checks++; if (o_resp[1] !== 2'd0 || o_resp[2] !== 2'd0 || o_resp[3] !== 2'd0) begin errors++; $display("FAIL single_others got %0d %0d %0d want 0", o_resp[1], o_resp[2], o_resp[3]); end
        tick();
        checks++; if (o_resp[0] !== 2'd0) begin errors++; $display("FAIL single_resp_pulse got %0d want 0", o_resp[0]); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'(p + 1); d1[p] = 32'(100 + p); d2[p] = 32'(200 + p);
        end
        tick();
        clear_inputs();
        for (int p = 0; p < 4; p++) begin
            tick();
            checks++; if (prio_port !== 2'(p) || prio_cmd !== 4'(p + 1) || prio_data1 !== 32'(100 + p)) begin
                errors++; $display("FAIL rr_order got port %0d cmd %0h want port %0d cmd %0h", prio_port, prio_cmd, p, p + 1); end
        end
        for (int p = 0; p < 4; p++) begin
            resp_in = 2'd3; resp_port = 2'(p); alu_out = 32'(300 + p);
            tick();
            checks++; if (o_resp[p] !== 2'd3 || o_data[p] !== 32'(300 + p)) begin
                errors++; $display("FAIL rr_resp%0d got %0d/%0d want 3/%0d", p + 1, o_resp[p], o_data[p], 300 + p); end
        end
        clear_inputs();
        cmd[0] = 4'd6; cmd[2] = 4'd8;
        tick();
        clear_inputs();
        tick();
        checks++; if (prio_port !== 2'd0 || prio_cmd !== 4'd6) begin errors++; $display("FAIL rr_second_first got port %0d cmd %0h want 0/6", prio_port, prio_cmd); end
        tick();
        checks++; if (prio_port !== 2'd2 || prio_cmd !== 4'd8) begin errors++; $display("FAIL rr_second_next got port %0d cmd %0h want 2/8", prio_port, prio_cmd); end
        $display("test_round_robin done");
    endtask

    task automatic test_stall();
        do_reset();
        alu_ready = 1'b0;
        cmd[1] = 4'd3; d1[1] = 32'h1111; d2[1] = 32'h2222;
        cmd[3] = 4'd4; d1[3] = 32'h3333; d2[3] = 32'h4444;
        tick();
        clear_inputs();
        alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL stall_cycle%0d got %0h want 0", i, prio_cmd); end
        end
        alu_ready = 1'b1;
        tick();
        checks++; if (prio_port !== 2'd1 || prio_cmd !== 4'd3 || prio_data1 !== 32'h1111 || prio_data2 !== 32'h2222) begin
            errors++; $display("FAIL stall_port2 got %0d %0h %0h %0h want 1 3 1111 2222", prio_port, prio_cmd, prio_data1, prio_data2); end
        tick();
        checks++; if (prio_port !== 2'd3 || prio_cmd !== 4'd4 || prio_data1 !== 32'h3333 || prio_data2 !== 32'h4444) begin
            errors++; $display("FAIL stall_port4 got %0d %0h %0h %0h want 3 4 3333 4444", prio_port, prio_cmd, prio_data1, prio_data2); end
        $display("test_stall done");
    endtask

    task automatic test_busy();
        do_reset();
        cmd[0] = 4'd1; d1[0] = 32'd3; d2[0] = 32'd4;
        tick();
        clear_inputs();
        tick();
        cmd[0] = 4'd2; d1[0] = 32'd99; d2[0] = 32'd98;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL busy_ignored%0d got %0h want 0", i, prio_cmd); end
        end
        clear_inputs();
        resp_in = 2'd1; resp_port = 2'd0; alu_out = 32'd77;
        tick();
        clear_inputs();
        checks++; if (o_resp[0] !== 2'd1 || o_data[0] !== 32'd77) begin errors++; $display("FAIL busy_resp got %0d/%0d want 1/77", o_resp[0], o_data[0]); end
        cmd[0] = 4'd2; d1[0] = 32'd9; d2[0] = 32'd10;
        tick();
        clear_inputs();
        tick();
        checks++; if (prio_cmd !== 4'd2 || prio_data1 !== 32'd9 || prio_data2 !== 32'd10 || prio_port !== 2'd0) begin
            errors++; $display("FAIL busy_reissue got %0h %0d %0d %0d want 2 9 10 0", prio_cmd, prio_data1, prio_data2, prio_port); end
        $display("test_busy done");
    endtask

    task automatic test_filter();
        do_reset();
        resp_in = 2'd2; resp_port = 2'd2; alu_out = 32'd55;
        tick();
        clear_inputs();
        for (int p = 0; p < 4; p++) begin
            checks++; if (o_resp[p] !== 2'd0 || o_data[p] !== '0) begin errors++; $display("FAIL filter_out%0d got %0d/%0h want 0/0", p + 1, o_resp[p], o_data[p]); end
        end
        checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL filter_grant got %0h want 0", prio_cmd); end
        cmd[2] = 4'd5; d1[2] = 32'd1; d2[2] = 32'd2;
        tick();
        clear_inputs();
        tick();
        checks++; if (prio_cmd !== 4'd5 || prio_port !== 2'd2) begin errors++; $display("FAIL filter_after got %0h/%0d want 5/2", prio_cmd, prio_port); end
        $display("test_filter done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cmd[0] = 4'd1; d1[0] = 32'd11; cmd[1] = 4'd2; d1[1] = 32'd22;
        tick();
        clear_inputs();
        tick();
        cmd[2] = 4'd3; d1[2] = 32'd33;
        tick();
        clear_inputs();
        alu_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_inputs();
        checks++; if (prio_cmd !== 4'd0 || prio_data1 !== '0 || prio_data2 !== '0 || prio_port !== 2'd0) begin
            errors++; $display("FAIL midreset_prio got %0h %0h %0h %0d want all 0", prio_cmd, prio_data1, prio_data2, prio_port); end
        for (int p = 0; p < 4; p++) begin
            checks++; if (o_resp[p] !== 2'd0 || o_data[p] !== '0) begin errors++; $display("FAIL midreset_out%0d got %0d/%0h want 0/0", p + 1, o_resp[p], o_data[p]); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (prio_cmd !== 4'd0) begin errors++; $display("FAIL midreset_nogrant%0d got %0h want 0", i, prio_cmd); end
        end
        resp_in = 2'd1; resp_port = 2'd0; alu_out = 32'd44;
        tick();
        clear_inputs();
        checks++; if (o_resp[0] !== 2'd0 || o_data[0] !== '0) begin errors++; $display("FAIL midreset_drop got %0d/%0h want 0/0", o_resp[0], o_data[0]); end
        $display("test_reset_midflight done");
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                cmd[p] = ($urandom % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                d1[p] = $urandom; d2[p] = $urandom;
            end
            alu_ready = ($urandom % 4) != 0;
            reset = ($urandom % 64) != 0;
            resp_in = '0; resp_port = 2'($urandom % 4); alu_out = $urandom;
            if ($urandom % 2 == 0) begin
                resp_in = 2'($urandom_range(1, 3));
                if ($urandom % 4 != 0) begin
                    for (int k = 0; k < 4; k++) begin
                        int p = (int'(resp_port) + k) % 4;
                        if (m_issued[p]) begin resp_port = 2'(p); break; end
                    end
                end
            end
            tick();
            bad = 0;
            checks++; if (prio_cmd !== e_cmd || prio_port !== e_port || prio_data1 !== e_d1 || prio_data2 !== e_d2) begin
                errors++; bad = 1;
                $display("FAIL rand_prio cyc %0d got %0h/%0d/%0h/%0h want %0h/%0d/%0h/%0h", cyc, prio_cmd, prio_port, prio_data1, prio_data2, e_cmd, e_port, e_d1, e_d2); end
            for (int p = 0; p < 4; p++) begin
                checks++; if (o_resp[p] !== e_resp[p] || o_data[p] !== e_data[p]) begin
                    errors++; bad = 1;
                    $display("FAIL rand_out%0d cyc %0d got %0d/%0h want %0d/%0h", p + 1, cyc, o_resp[p], o_data[p], e_resp[p], e_data[p]); end
            end
            if (bad == 0 && (e_cmd != 0 || resp_in != 0))
                $display("rand cyc %0d grant %0h port %0d resp %0d port %0d", cyc, e_cmd, e_port, resp_in, resp_port);
        end
        reset = 1'b1;
        clear_inputs();
        $display("test_random done");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_busy();
        test_filter();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_port_arbiter.md
# alu_port_arbiter

Four-port request scheduler in front of `alu_input_stage`. It captures one command per requester port and grants the shared ALU input stage round-robin, one command per cycle. It drives `prio_cmd`/`prio_data1`/`prio_data2` with the issuing port's ID. ALU responses tagged with that ID are routed back to the originating port's output, and the port is then released for its next command.

## Interface
Parameters:
- `DW`, default 32: operand and result width.
- `NP`, fixed 4: number of requester ports. Not overridable.

Ports:
- `c_clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `c_clk`.
- `reqN_cmd_in` in 4 (N=1..4): command from port N. 0 = no-op.
- `reqN_data1_in`, `reqN_data2_in` in DW: operands for port N, valid in the same cycle as a non-zero command.
- `alu_ready` in 1: ALU input stage can accept a command this cycle.
- `alu_resp_in` in 2: response code from the ALU. 0 = none.
- `alu_resp_port` in 2: port ID (0..3 = port 1..4) that the response belongs to.
- `alu_out_in` in DW: result data accompanying `alu_resp_in`.
- `prio_cmd` out 4: granted command, non-zero for exactly one cycle per grant.
- `prio_data1`, `prio_data2` out DW: operands of the granted command.
- `prio_port` out 2: ID of the granted port.
- `outN_resp` out 2: response code routed to port N, one-cycle pulse.
- `outN_data` out DW: result routed to port N, valid while `outN_resp` is non-zero.

## Operation
Each port has a 3-state FSM.
- IDLE
  - If `reqN_cmd_in != 0`: capture cmd, data1, data2 into the port holding register and go to PEND.
- PEND
  - Wait for a grant.
  - On grant, go to WAIT.
- WAIT
  - Issued; awaiting response.
  - When `alu_resp_in != 0` and `alu_resp_port == N-1`, go to IDLE.

Commands presented while a port is in PEND or WAIT are ignored, with no capture and no side effect.

Arbitration:
- Runs in any cycle with `alu_ready=1` and at least one port in PEND.
- Round-robin pointer `last` (2 bits). Search order is `last+1, last+2, last+3, last`, mod 4.
- The first PEND port found is granted, and `last` is set to that port.
- At most one grant per cycle. Back-to-back grants are allowed.

Issue:
- On a grant edge, register the held cmd/data1/data2 onto `prio_cmd`/`prio_data1`/`prio_data2`, with `prio_port` = granted ID.
- In any cycle without a grant, `prio_cmd` = 0. `prio_data*` and `prio_port` hold their last values.
- `alu_ready=0` means no grant. PEND ports keep their contents indefinitely.

Response routing:
- When `alu_resp_in != 0`, register `alu_resp_in` and `alu_out_in` onto `outN_resp`/`outN_data` for N = `alu_resp_port` + 1.
- All other ports' `out*_resp` = 0 that cycle.
- A response for a port not in WAIT is dropped: all `out*_resp` stay 0 and no state changes.

Simultaneous events:
- Capture and response for different ports in the same cycle are independent.
- A port receiving its response at edge t is IDLE after t. A command presented in the cycle after edge t is captured at edge t+1.
- Capture and grant never coincide for one port, because a port must be in PEND for one edge before it can be granted.
- Both the ALU stage and the arbiter tolerate a response and a grant in the same edge.

## Timing
Reset (`reset=0` at an edge):
- All port FSMs go to IDLE and holding registers clear.
- `last` = 3, so port 1 has first priority.
- All outputs go to 0: `prio_cmd`, `prio_data1`, `prio_data2`, `prio_port`, all `outN_resp`, all `outN_data`.
- Reset mid-operation discards PEND and WAIT state. Responses arriving after reset for pre-reset commands are dropped, since their ports are IDLE.

Latency:
- Request in cycle 0 is captured at edge 1. `prio_cmd` is valid after edge 2, when uncontended with `alu_ready=1`.
- Response in cycle k appears on `outN_*` after edge k+1.

Throughput: one grant per cycle. Each port has at most one outstanding command.

## Test plan
- **Single command:** reset, then `req1_cmd_in=1`, data 5/7 for one cycle. Expect `prio_cmd=1`, `prio_data1=5`, `prio_data2=7`, `prio_port=0` for one cycle, 2 edges later. Then `alu_resp_in=1`, `alu_resp_port=0`, `alu_out_in=12`. Expect `out1_resp=1`, `out1_data=12` one cycle later, and `out2..4_resp=0`.
- **Fair round-robin:** all four ports request in the same cycle with `alu_ready=1`. Expect `prio_port` sequence 0,1,2,3 on consecutive cycles. After all respond and port 1 and port 3 re-request simultaneously with `last=3`, port 1 is granted first, then port 3.
- **Stall:** hold `alu_ready=0` with ports 2 and 4 in PEND for 5 cycles. Expect `prio_cmd=0` throughout. Raise `alu_ready`: port 2 is granted, then port 4 the next cycle, with captured data intact.
- **Busy port:** port 1 in WAIT and `req1_cmd_in=2` applied. Expect no capture and no grant. After the response, a new `req1_cmd_in=2` is issued normally.
- **Response filtering:** `alu_resp_in=2` with `alu_resp_port=2` while port 3 is IDLE. Expect all `out*_resp=0` and no state change.
- **Reset mid-flight:** ports 1 and 2 in WAIT and port 3 in PEND, then `reset=0` for one edge. Expect all outputs 0 and no further grants. A subsequent response for port 1 is dropped.
